pixel_fb_writer: RTL and testbench

- Consumer end of the rasterizer pixel stream: color, valid, x/y, width/height, draw, ready and frame_end.
- Converts accepted pixels into linear framebuffer writes at address y*width+x.
- Buffers pixels in a small FIFO and applies backpressure through in_ready.
- Clears the framebuffer at frame start and signals frame_done once every pixel of the frame is written.

---
 rtl/pixel_fb_writer_if.sv | 26 ++
 rtl/pixel_fb_writer.sv | 130 +++++++++++++
 tb/tb_pixel_fb_writer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fb_writer_if.sv
// Rasterizer pixel stream plus framebuffer write port, seen from the writer as the slave side.
interface pixel_fb_writer_if #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned COLOR_W = 8
) ();
  logic [COLOR_W-1:0] in_color;
  logic               in_valid;
  logic [10:0]        in_x;
  logic [10:0]        in_y;
  logic               in_draw;
  logic               in_ready;
  logic               fb_wr_en;
  logic [ADDR_W-1:0]  fb_wr_addr;
  logic [COLOR_W-1:0] fb_wr_data;
  logic               fb_wr_ready;

  modport master (
    output in_color, in_valid, in_x, in_y, in_draw, fb_wr_ready,
    input  in_ready, fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport slave (
    input  in_color, in_valid, in_x, in_y, in_draw, fb_wr_ready,
    output in_ready, fb_wr_en, fb_wr_addr, fb_wr_data
  );
endinterface

// File: rtl/pixel_fb_writer.sv
// Clears the frame, then turns accepted pixels into writes at y*W+x; 1-cycle pixel-to-write latency.
// in_ready drops when the pixel FIFO is full; fb_wr_* hold until fb_wr_ready.
module pixel_fb_writer #(
  parameter int unsigned        ADDR_W      = 19,
  parameter int unsigned        COLOR_W     = 8,
  parameter int unsigned        FIFO_DEPTH  = 8,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic [10:0]      in_width,
  input  logic [10:0]      in_height,
  input  logic             in_frame_end,
  pixel_fb_writer_if.slave px,
  output logic             busy,
  output logic             frame_done,
  output logic [31:0]      pixel_count,
  output logic [15:0]      drop_count
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_t;

  state_t        state_q;
  logic [10:0]   w_q;
  logic [10:0]   h_q;
  logic [21:0]   area_q;
  logic [21:0]   clear_addr_q;
  logic [31:0]   pixel_count_q;
  logic [15:0]   drop_count_q;
  pix_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [PW:0]   cnt_q;

  logic        fifo_full, fifo_ne, draining, accept, in_bounds;
  logic        push, pop, drop, clr_xfer, clr_last;
  logic [21:0] row_base, new_area;
  pix_t        head, in_pix;

  assign fifo_full = (cnt_q == FULL_CNT);
  assign fifo_ne   = (cnt_q != '0);
  assign draining  = (state_q == DRAW) || (state_q == FLUSH);
  assign head      = mem_q[rp_q];

  assign px.in_ready = (state_q == DRAW) && !fifo_full;
  assign accept      = px.in_valid && px.in_ready;
  assign in_bounds   = (px.in_x < w_q) && (px.in_y < h_q);
  assign row_base    = 22'(px.in_y) * 22'(w_q);
  assign in_pix.addr  = ADDR_W'(23'(row_base) + 23'(px.in_x));
  assign in_pix.color = px.in_color;

  // A frame_start edge discards whatever arrives with it; the new frame starts clean.
  assign push     = accept && px.in_draw && in_bounds && !frame_start;
  assign drop     = accept && px.in_draw && !in_bounds;
  assign pop      = draining && fifo_ne && px.fb_wr_ready;
  assign clr_xfer = (state_q == CLEAR) && px.fb_wr_ready;
  assign clr_last = (clear_addr_q == area_q - 22'd1);
  assign new_area = 22'(in_width) * 22'(in_height);

  assign px.fb_wr_en   = (state_q == CLEAR) || (draining && fifo_ne);
  assign px.fb_wr_addr = (state_q == CLEAR) ? ADDR_W'(clear_addr_q) :
                         (draining && fifo_ne) ? head.addr : '0;
  assign px.fb_wr_data = (state_q == CLEAR) ? CLEAR_COLOR :
                         (draining && fifo_ne) ? head.color : '0;

  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign pixel_count = pixel_count_q;
  assign drop_count  = drop_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      w_q           <= '0;
      h_q           <= '0;
      area_q        <= '0;
      clear_addr_q  <= '0;
      pixel_count_q <= '0;
      drop_count_q  <= '0;
      wp_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
    end else if (frame_start) begin
      w_q           <= in_width;
      h_q           <= in_height;
      area_q        <= new_area;
      clear_addr_q  <= '0;
      pixel_count_q <= '0;
      drop_count_q  <= '0;
      wp_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
      state_q       <= (new_area == '0) ? DRAW : CLEAR;
    end else begin
      if (push) wp_q <= wp_q + PTR_ONE;
      if (pop) begin
        rp_q          <= rp_q + PTR_ONE;
        pixel_count_q <= pixel_count_q + 32'd1;
      end
      if (push && !pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (!push && pop) cnt_q <= cnt_q - CNT_ONE;
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;

      case (state_q)
        CLEAR: if (clr_xfer) begin
          clear_addr_q <= clear_addr_q + 22'd1;
          if (clr_last) state_q <= DRAW;
        end
        DRAW:  if (in_frame_end) state_q <= FLUSH;
        FLUSH: if (!fifo_ne) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_pix;
  end
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench: expected-write queue model checked every cycle, plus literal per-scenario checks.
module tb_pixel_fb_writer;
  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic [10:0] in_width;
  logic [10:0] in_height;
  logic        in_frame_end;
  logic        busy;
  logic        frame_done;
  logic [31:0] pixel_count;
  logic [15:0] drop_count;

  pixel_fb_writer_if #(.ADDR_W(19), .COLOR_W(8)) px ();

  pixel_fb_writer #(.ADDR_W(19), .COLOR_W(8), .FIFO_DEPTH(8), .CLEAR_COLOR(8'h00)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .in_width     (in_width),
    .in_height    (in_height),
    .in_frame_end (in_frame_end),
    .px           (px),
    .busy         (busy),
    .frame_done   (frame_done),
    .pixel_count  (pixel_count),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
    logic        clr;
  } wr_t;

  wr_t         exp_q[$];
  logic [18:0] log_a[$];
  logic [7:0]  log_d[$];
  int          m_pix = 0;
  int          m_drop = 0;
  int          clr_seen = 0;
  int          fd_cnt = 0;
  int          cur_w = 0;
  int          cur_h = 0;

  // Model: every write the framebuffer must see, in order; counters follow from the writes and drops.
  always @(negedge clk) begin
    wr_t e;
    if (!reset_n) begin
      exp_q.delete();
      m_pix  = 0;
      m_drop = 0;
    end else begin
      chk("pixel_count_track", pixel_count, 64'(m_pix));
      chk("drop_count_track", drop_count, 64'(m_drop));
      if (frame_done) fd_cnt++;
      if (px.fb_wr_en && px.fb_wr_ready) begin
        log_a.push_back(px.fb_wr_addr);
        log_d.push_back(px.fb_wr_data);
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", px.fb_wr_addr, e.addr);
          chk("wr_data", px.fb_wr_data, e.data);
          if (e.clr) clr_seen++;
          else m_pix++;
        end
      end
      if (frame_start) begin
        exp_q.delete();
        m_pix    = 0;
        m_drop   = 0;
        clr_seen = 0;
        cur_w    = int'(in_width);
        cur_h    = int'(in_height);
        for (int a = 0; a < cur_w * cur_h; a++) exp_q.push_back('{addr: 19'(a), data: 8'h00, clr: 1'b1});
      end else if (px.in_valid && px.in_ready && px.in_draw) begin
        if (int'(px.in_x) < cur_w && int'(px.in_y) < cur_h)
          exp_q.push_back('{addr: 19'(int'(px.in_y) * cur_w + int'(px.in_x)), data: px.in_color, clr: 1'b0});
        else if (m_drop != 65535)
          m_drop++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int h);
    in_width    = 11'(w);
    in_height   = 11'(h);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic set_px(input int x, input int y, input int c, input logic d);
    px.in_x     = 11'(x);
    px.in_y     = 11'(y);
    px.in_color = 8'(c);
    px.in_draw  = d;
  endtask

  task automatic send_px(input int x, input int y, input int c, input logic d, output bit ok);
    set_px(x, y, c, d);
    px.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = px.in_ready;
      tick();
    end
    px.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 200 && !px.in_ready; i++) tick();
    ok = px.in_ready;
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 200 && busy; i++) tick();
    ok = !busy;
  endtask

  initial begin
    bit ok;
    int base, fd0, idx;
    logic acc;

    reset_n = 1'b0; frame_start = 1'b0; in_width = '0; in_height = '0; in_frame_end = 1'b0;
    px.in_color = '0; px.in_valid = 1'b0; px.in_x = '0; px.in_y = '0; px.in_draw = 1'b0;
    px.fb_wr_ready = 1'b1;
    #3;
    chk("rst_in_ready", px.in_ready, 0);
    chk("rst_fb_wr_en", px.fb_wr_en, 0);
    chk("rst_fb_wr_addr", px.fb_wr_addr, 0);
    chk("rst_fb_wr_data", px.fb_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pixel_count", pixel_count, 0);
    chk("rst_drop_count", drop_count, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset in the middle of a 4x4 clear, after five clear writes
    start_frame(4, 4);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (clr_seen >= 5);
    end
    chk("s1_five_clears", ok, 1);
    chk("s1_busy_before_reset", busy, 1);
    reset_n = 1'b0;
    #2;
    chk("s1_fb_wr_en", px.fb_wr_en, 0);
    chk("s1_fb_wr_addr", px.fb_wr_addr, 0);
    chk("s1_busy", busy, 0);
    chk("s1_in_ready", px.in_ready, 0);
    base = log_a.size();
    tick(); tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("s1_no_writes_after_reset", log_a.size() - base, 0);
    chk("s1_idle", busy, 0);

    // 4x2 clear, then DRAW
    base = log_a.size();
    start_frame(4, 2);
    wait_ready(ok);
    chk("s2_reached_draw", ok, 1);
    chk("s2_clear_writes", log_a.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      chk("s2_clear_addr", log_a[base + k], 64'(k));
      chk("s2_clear_data", log_d[base + k], 0);
    end

    // Two pixels then frame end
    fd0  = fd_cnt;
    base = log_a.size();
    send_px(1, 1, 8'h5A, 1'b1, ok);
    chk("s3_px1_accepted", ok, 1);
    send_px(3, 0, 8'hC3, 1'b1, ok);
    chk("s3_px2_accepted", ok, 1);
    in_frame_end = 1'b1;
    wait_idle(ok);
    in_frame_end = 1'b0;
    chk("s3_idle", ok, 1);
    chk("s3_write_count", log_a.size() - base, 2);
    chk("s3_w0_addr", log_a[base], 5);
    chk("s3_w0_data", log_d[base], 8'h5A);
    chk("s3_w1_addr", log_a[base + 1], 3);
    chk("s3_w1_data", log_d[base + 1], 8'hC3);
    chk("s3_pixel_count", pixel_count, 2);
    chk("s3_frame_done_pulses", fd_cnt - fd0, 1);

    // Backpressure: ten pixels offered with the framebuffer stalled
    start_frame(4, 4);
    wait_ready(ok);
    chk("s4_reached_draw", ok, 1);
    px.fb_wr_ready = 1'b0;
    base = log_a.size();
    idx = 0;
    set_px(0, 0, 8'h10, 1'b1);
    px.in_valid = 1'b1;
    repeat (12) begin
      acc = px.in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 10) set_px(idx % 4, idx / 4, 16 + idx, 1'b1);
        else px.in_valid = 1'b0;
      end
    end
    chk("s4_accepts_when_stalled", idx, 8);
    chk("s4_in_ready_low", px.in_ready, 0);
    chk("s4_no_write_while_stalled", log_a.size() - base, 0);
    px.fb_wr_ready = 1'b1;
    for (int i = 0; i < 40 && idx < 10; i++) begin
      acc = px.in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 10) set_px(idx % 4, idx / 4, 16 + idx, 1'b1);
        else px.in_valid = 1'b0;
      end
    end
    px.in_valid = 1'b0;
    chk("s4_all_accepted", idx, 10);
    in_frame_end = 1'b1;
    wait_idle(ok);
    in_frame_end = 1'b0;
    chk("s4_idle", ok, 1);
    chk("s4_write_count", log_a.size() - base, 10);
    for (int k = 0; k < 10; k++) begin
      chk("s4_addr_order", log_a[base + k], 64'(k));
      chk("s4_data_order", log_d[base + k], 64'(16 + k));
    end
    chk("s4_pixel_count", pixel_count, 10);

    // Out-of-bounds and draw=0 pixels
    start_frame(4, 2);
    wait_ready(ok);
    chk("s5_reached_draw", ok, 1);
    base = log_a.size();
    send_px(4, 0, 8'hAA, 1'b1, ok);
    chk("s5_x_oob_accepted", ok, 1);
    send_px(0, 7, 8'hBB, 1'b1, ok);
    chk("s5_y_oob_accepted", ok, 1);
    send_px(1, 0, 8'hCC, 1'b0, ok);
    chk("s5_nodraw_accepted", ok, 1);
    send_px(2, 1, 8'h77, 1'b1, ok);
    chk("s5_good_accepted", ok, 1);
    in_frame_end = 1'b1;
    wait_idle(ok);
    in_frame_end = 1'b0;
    chk("s5_idle", ok, 1);
    chk("s5_drop_count", drop_count, 2);
    chk("s5_pixel_count", pixel_count, 1);
    chk("s5_write_count", log_a.size() - base, 1);
    chk("s5_addr", log_a[base], 6);
    chk("s5_data", log_d[base], 8'h77);

    // Abort during FLUSH with three queued pixels
    start_frame(4, 2);
    wait_ready(ok);
    chk("s6_reached_draw", ok, 1);
    px.fb_wr_ready = 1'b0;
    send_px(0, 0, 8'h11, 1'b1, ok);
    send_px(1, 0, 8'h22, 1'b1, ok);
    send_px(2, 0, 8'h33, 1'b1, ok);
    chk("s6_third_accepted", ok, 1);
    in_frame_end = 1'b1;
    tick(); tick();
    chk("s6_flush_busy", busy, 1);
    chk("s6_flush_pending", px.fb_wr_en, 1);
    chk("s6_flush_in_ready", px.in_ready, 0);
    in_frame_end = 1'b0;
    fd0  = fd_cnt;
    base = log_a.size();
    start_frame(4, 2);
    chk("s6_clear_en", px.fb_wr_en, 1);
    chk("s6_clear_addr0", px.fb_wr_addr, 0);
    chk("s6_clear_data0", px.fb_wr_data, 0);
    px.fb_wr_ready = 1'b1;
    wait_ready(ok);
    chk("s6_reached_draw", ok, 1);
    chk("s6_only_clears", log_a.size() - base, 8);
    chk("s6_first_clear", log_a[base], 0);
    chk("s6_last_clear", log_a[base + 7], 7);
    chk("s6_no_frame_done", fd_cnt - fd0, 0);
    in_frame_end = 1'b1;
    wait_idle(ok);
    in_frame_end = 1'b0;
    chk("s6_idle", ok, 1);
    chk("s6_frame_done_after", fd_cnt - fd0, 1);
    chk("s6_pixel_count", pixel_count, 0);

    tick();
    chk("end_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
